// File: rtl/alu_pkg.sv
// Shared encodings for the bit-serial ALU: operation codes, FSM states, ctrl layout.
package alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SLT = 2'b11;

  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] FIX  = 2'b10;

  localparam int unsigned CTRL_A_INV = 3;
  localparam int unsigned CTRL_B_INV = 2;
  localparam int unsigned CTRL_OP_HI = 1;
  localparam int unsigned CTRL_OP_LO = 0;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic [1:0] operation;
  } ctrl_t;

  // AND/OR need no carry chain
  function automatic logic is_logic_op(input logic [1:0] op);
    return !op[1];
  endfunction

endpackage

// File: rtl/serial_alu_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/full-add.
// The SLT bit is produced at the top level, so the slice yields 0 for OP_SLT.
module serial_alu_slice
  import alu_pkg::*;
(
  input  logic       a,
  input  logic       b,
  input  logic       a_invert,
  input  logic       b_invert,
  input  logic       carry_in,
  input  logic [1:0] operation,
  output logic       result,
  output logic       sum,
  output logic       carry_out
);

  logic a_eff;
  logic b_eff;

  // Inverted operands, full adder and operation select
  always_comb begin
    a_eff     = a ^ a_invert;
    b_eff     = b ^ b_invert;
    sum       = a_eff ^ b_eff ^ carry_in;
    carry_out = (a_eff & b_eff) | (carry_in & (a_eff ^ b_eff));
    case (operation)
      OP_AND:  result = a_eff & b_eff;
      OP_OR:   result = a_eff | b_eff;
      OP_ADD:  result = sum;
      default: result = 1'b0;
    endcase
  end

endmodule

// File: rtl/serial_alu.sv
// Bit-serial ALU: one bit per clock, LSB first, carry and MSB flags held between clocks.
// Optional macro SERIAL_ALU_FAST_LOGIC_EN: AND/OR complete bit-parallel, skipping RUN.
module serial_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       alu_ctrl,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             overflow
);

  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]       state, state_n;
  logic [CW-1:0]    count, count_n;
  logic             carry, carry_n;
  logic [WIDTH-1:0] a_sh, a_n;
  logic [WIDTH-1:0] b_sh, b_n;
  ctrl_t            ctrl, ctrl_n;
  logic             msb_ovf, msb_ovf_n;
  logic             msb_set, msb_set_n;
  logic             busy_n, done_n, zero_n, overflow_n;
  logic [WIDTH-1:0] result_n;
  logic [WIDTH-1:0] fix_res;

  logic s_res, s_sum, s_cout;

  serial_alu_slice u_slice (
    .a         (a_sh[0]),
    .b         (b_sh[0]),
    .a_invert  (ctrl.a_invert),
    .b_invert  (ctrl.b_invert),
    .carry_in  (carry),
    .operation (ctrl.operation),
    .result    (s_res),
    .sum       (s_sum),
    .carry_out (s_cout)
  );

  // Next-state and datapath update
  always_comb begin
    state_n    = state;
    count_n    = count;
    carry_n    = carry;
    a_n        = a_sh;
    b_n        = b_sh;
    ctrl_n     = ctrl;
    msb_ovf_n  = msb_ovf;
    msb_set_n  = msb_set;
    busy_n     = busy;
    done_n     = 1'b0;
    zero_n     = zero;
    overflow_n = overflow;
    result_n   = result;
    fix_res    = result;
    case (state)
      IDLE: begin
        if (start) begin
          a_n     = src_a;
          b_n     = src_b;
          ctrl_n  = '{a_invert:  alu_ctrl[CTRL_A_INV],
                      b_invert:  alu_ctrl[CTRL_B_INV],
                      operation: alu_ctrl[CTRL_OP_HI:CTRL_OP_LO]};
          // b_invert doubles as the +1 of two's-complement subtraction
          carry_n = alu_ctrl[CTRL_B_INV];
          count_n = '0;
          busy_n  = 1'b1;
          state_n = RUN;
`ifdef SERIAL_ALU_FAST_LOGIC_EN
          if (is_logic_op(alu_ctrl[CTRL_OP_HI:CTRL_OP_LO])) state_n = FIX;
`endif
        end
      end
      RUN: begin
        a_n      = a_sh >> 1;
        b_n      = b_sh >> 1;
        result_n = {s_res, result[WIDTH-1:1]};
        carry_n  = s_cout;
        count_n  = count + CW'(1);
        if (count == LAST) begin
          msb_ovf_n = carry ^ s_cout;
          msb_set_n = s_sum ^ (carry ^ s_cout);
          state_n   = FIX;
        end
      end
      FIX: begin
        overflow_n = msb_ovf;
        if (ctrl.operation == OP_SLT) begin
          fix_res    = {{(WIDTH-1){1'b0}}, msb_set};
          overflow_n = 1'b0;
        end
`ifdef SERIAL_ALU_FAST_LOGIC_EN
        if (is_logic_op(ctrl.operation)) begin
          if (ctrl.operation == OP_AND)
            fix_res = (a_sh ^ {WIDTH{ctrl.a_invert}}) & (b_sh ^ {WIDTH{ctrl.b_invert}});
          else
            fix_res = (a_sh ^ {WIDTH{ctrl.a_invert}}) | (b_sh ^ {WIDTH{ctrl.b_invert}});
          overflow_n = 1'b0;
        end
`endif
        result_n = fix_res;
        zero_n   = (fix_res == '0);
        done_n   = 1'b1;
        busy_n   = 1'b0;
        state_n  = IDLE;
      end
      default: begin
        state_n = IDLE;
        busy_n  = 1'b0;
      end
    endcase
  end

  // FSM state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // Datapath and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      carry    <= 1'b0;
      a_sh     <= '0;
      b_sh     <= '0;
      ctrl     <= '0;
      msb_ovf  <= 1'b0;
      msb_set  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      zero     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
    end else begin
      count    <= count_n;
      carry    <= carry_n;
      a_sh     <= a_n;
      b_sh     <= b_n;
      ctrl     <= ctrl_n;
      msb_ovf  <= msb_ovf_n;
      msb_set  <= msb_set_n;
      busy     <= busy_n;
      done     <= done_n;
      zero     <= zero_n;
      overflow <= overflow_n;
      result   <= result_n;
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Scoreboard bench for serial_alu: random + directed ops against an arithmetic model.
// Honours SERIAL_ALU_FAST_LOGIC_EN for expected AND/OR latency and overflow.
module tb_serial_alu;

  localparam int unsigned W = 32;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] src_a = '0;
  logic [W-1:0] src_b = '0;
  logic [3:0]   alu_ctrl = '0;
  logic         busy, done, zero, overflow;
  logic [W-1:0] result;

  serial_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .src_a(src_a), .src_b(src_b),
    .alu_ctrl(alu_ctrl), .busy(busy), .done(done), .result(result),
    .zero(zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] res;
    logic         z;
    logic         ov;
    int unsigned  due;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain two's-complement arithmetic on the (optionally inverted) operands
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [3:0] c, input int unsigned acc);
    exp_t m;
    logic [W-1:0] ai, bi, sum, r;
    logic [W:0] s;
    logic ov;
    int unsigned lat;
    ai  = c[3] ? ~a : a;
    bi  = c[2] ? ~b : b;
    s   = {1'b0, ai} + {1'b0, bi} + (W+1)'(c[2]);
    sum = s[W-1:0];
    ov  = (ai[W-1] == bi[W-1]) && (sum[W-1] != ai[W-1]);
    r   = '0;
    case (c[1:0])
      2'd0: r = ai & bi;
      2'd1: r = ai | bi;
      2'd2: r = sum;
      default: begin
        r[0] = sum[W-1] ^ ov;
        ov = 1'b0;
      end
    endcase
    lat = W + 1;
`ifdef SERIAL_ALU_FAST_LOGIC_EN
    if (!c[1]) begin
      lat = 1;
      ov = 1'b0;
    end
`endif
    m.res = r;
    m.z   = (r == '0);
    m.ov  = ov;
    m.due = acc + lat;
    return m;
  endfunction

  // Monitor: every done pulse pops one expectation
  always @(negedge clk) begin
    if (!rst && done) begin
      if (q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_done actual_result=%0h required=no_done", result);
      end else begin
        e = q.pop_front();
        chk("result", 64'(result), 64'(e.res));
        chk("zero", 64'(zero), 64'(e.z));
        chk("overflow", 64'(overflow), 64'(e.ov));
        chk("latency_cycle", 64'(cyc), 64'(e.due));
        chk("busy_at_done", 64'(busy), 64'd0);
      end
    end
  end

  // Drive a request at the current negedge; expectation pushed once the accept edge has passed
  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [3:0] c, input bit push);
    start = 1'b1;
    src_a = a;
    src_b = b;
    alu_ctrl = c;
    @(posedge clk);
    #1;
    if (push) q.push_back(model(a, b, c, cyc));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else @(negedge clk);
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL busy_timeout actual=busy required=idle");
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_done", 64'(done), 64'd0);
    chk("reset_result", 64'(result), 64'd0);
    chk("reset_zero", 64'(zero), 64'd0);
    chk("reset_overflow", 64'(overflow), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    issue(32'd5, 32'd3, 4'b0010, 1'b1);              wait_idle();
    issue(32'h7FFF_FFFF, 32'hFFFF_FFFF, 4'b0110, 1); wait_idle();
    issue(32'h8000_0000, 32'h7FFF_FFFF, 4'b0111, 1); wait_idle();
    issue(32'd5, 32'd5, 4'b0111, 1'b1);              wait_idle();
    issue(32'd0, 32'd0, 4'b1100, 1'b1);              wait_idle();
    issue(32'd7, 32'd7, 4'b0110, 1'b1);              wait_idle();
    issue(32'hFFFF_FFFF, 32'd1, 4'b0010, 1'b1);      wait_idle();
    issue(32'h0000_F0F0, 32'h0000_FF00, 4'b0000, 1); wait_idle();

    // Starts while busy must be ignored
    issue(32'd100, 32'd23, 4'b0010, 1'b1);
    repeat (3) begin
      @(negedge clk);
      start = 1'b1;
      src_a = W'($urandom);
      src_b = W'($urandom);
      alu_ctrl = 4'($urandom);
      @(negedge clk);
      start = 1'b0;
    end
    wait_idle();

    // Back-to-back: second start lands in the done cycle of the first
    issue(32'h1234_5678, 32'h1111_1111, 4'b0110, 1'b1);
    wait_idle();
    issue(32'hDEAD_BEEF, 32'h0F0F_0F0F, 4'b0001, 1'b1);
    wait_idle();

    // Reset mid-operation: async clear, no done
    issue(32'hFFFF_0000, 32'h7FFF_FFFF, 4'b0010, 1'b0);
    repeat (9) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_result", 64'(result), 64'd0);
    chk("midrst_flags", 64'({zero, overflow}), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    issue(32'd40, 32'd2, 4'b0010, 1'b1);             wait_idle();

    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      issue(pick(), pick(), 4'($urandom_range(0, 15)), 1'b1);
      wait_idle();
    end

    for (int i = 0; i < 100 && q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", 64'(q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
